// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed display scanner.
// Segment vectors are packed {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    typedef enum logic [1:0] {
        BLANK_T = 2'd0,
        SHOW_T  = 2'd1,
        BLANK_O = 2'd2,
        SHOW_O  = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_ZERO_N = 7'b1000000;

    typedef struct packed {
        logic [6:0] tens;
        logic [6:0] units;
    } seg_pair_t;

    localparam seg_pair_t SHADOW_RST = '{tens: SEG_BLANK, units: SEG_BLANK};

    function automatic logic is_blank_state(scan_state_t s);
        return (s == BLANK_T) || (s == BLANK_O);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter: counts 0..load while running, pulses tc on the last count.
// Holds at 0 when stopped so a restart always begins a full dwell.
module scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [W-1:0] load,
    output logic [W-1:0] cnt_nxt,
    output logic         tc
);

    logic [W-1:0] cnt;

    // >= rather than == so an out-of-range count reloads instead of wrapping
    assign tc = run && (cnt >= load);

    always_comb begin
        cnt_nxt = cnt;
        if (!run) begin
            cnt_nxt = '0;
        end else if (tc) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/display_scan.sv
// Two-digit time-multiplexed 7-segment scanner with dead-time blanking,
// per-frame input snapshot and optional tens leading-zero suppression.
module display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic seg1_a,
    input  logic seg1_b,
    input  logic seg1_c,
    input  logic seg1_d,
    input  logic seg1_e,
    input  logic seg1_f,
    input  logic seg1_g,
    input  logic seg2_a,
    input  logic seg2_b,
    input  logic seg2_c,
    input  logic seg2_d,
    input  logic seg2_e,
    input  logic seg2_f,
    input  logic seg2_g,
    output logic seg_a,
    output logic seg_b,
    output logic seg_c,
    output logic seg_d,
    output logic seg_e,
    output logic seg_f,
    output logic seg_g,
    output logic an1,
    output logic an0,
    output logic frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LIM  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

    scan_state_t  state;
    scan_state_t  state_nxt;
    seg_pair_t    shadow;
    seg_pair_t    shadow_nxt;
    seg_pair_t    seg_in;
    logic [CW-1:0] load;
    logic [CW-1:0] cnt_nxt;
    logic         tc;
    logic         capture;

    logic [6:0]   seg_q;
    logic [6:0]   seg_d_nxt;
    logic         an1_q;
    logic         an0_q;
    logic         ft_q;
    logic         an1_nxt;
    logic         an0_nxt;
    logic         ft_nxt;

    assign seg_in.tens  = {seg1_g, seg1_f, seg1_e, seg1_d,
                           seg1_c, seg1_b, seg1_a};
    assign seg_in.units = {seg2_g, seg2_f, seg2_e, seg2_d,
                           seg2_c, seg2_b, seg2_a};

    assign load = is_blank_state(state) ? BLANK_LIM : SHOW_LIM;

    scan_timer #(
        .W (CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (en),
        .load    (load),
        .cnt_nxt (cnt_nxt),
        .tc      (tc)
    );

    // Snapshot only when the tens slot opens, so both digits agree
    assign capture    = tc && (state == BLANK_T);
    assign shadow_nxt = capture ? seg_in : shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= BLANK_T;
            shadow <= SHADOW_RST;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = BLANK_T;
        end else if (tc) begin
            unique case (state)
                BLANK_T: state_nxt = SHOW_T;
                SHOW_T:  state_nxt = BLANK_O;
                BLANK_O: state_nxt = SHOW_O;
                SHOW_O:  state_nxt = BLANK_T;
                default: state_nxt = BLANK_T;
            endcase
        end
    end

    // Output decode works on next-state values so the registered
    // outputs line up with the state register, with no extra latency.
    always_comb begin
        seg_d_nxt = SEG_BLANK;
        an1_nxt   = 1'b1;
        an0_nxt   = 1'b1;
        ft_nxt    = 1'b0;
        unique case (state_nxt)
            SHOW_T: begin
                if (!((LZ_SUPPRESS != 0) &&
                      (shadow_nxt.tens == SEG_ZERO_N))) begin
                    an1_nxt   = 1'b0;
                    seg_d_nxt = shadow_nxt.tens;
                end
            end
            SHOW_O: begin
                an0_nxt   = 1'b0;
                seg_d_nxt = shadow_nxt.units;
                ft_nxt    = (cnt_nxt == SHOW_LIM);
            end
            default: begin
                seg_d_nxt = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            an1_q <= 1'b1;
            an0_q <= 1'b1;
            ft_q  <= 1'b0;
        end else begin
            seg_q <= seg_d_nxt;
            an1_q <= an1_nxt;
            an0_q <= an0_nxt;
            ft_q  <= ft_nxt;
        end
    end

    assign {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a} = seg_q;
    assign an1        = an1_q;
    assign an0        = an0_q;
    assign frame_tick = ft_q;

endmodule
